mem_stage: RTL and testbench

//  Memory-access stage that consumes the EX->MEM pipe register outputs (ls_address, is_load/is_store, ls_size, src2).

---
 rtl/mem_stage_pkg.sv | 35 +++
 rtl/mem_stage_load_formatter.sv | 33 +++
 rtl/mem_stage.sv | 130 +++++++++++++
 tb/tb_mem_stage.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access stage: access sizes, FSM states, byte masks.
// Latency: none (constants and a combinational helper only).
// Backpressure: not applicable.
package mem_stage_pkg;

  // One-hot access size as produced by decode
  localparam logic [3:0] SZ_B = 4'b0001;
  localparam logic [3:0] SZ_H = 4'b0010;
  localparam logic [3:0] SZ_W = 4'b0100;
  localparam logic [3:0] SZ_D = 4'b1000;

  // Unshifted byte-lane masks for each size
  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Byte mask for a one-hot size; an illegal size yields no lanes
  function automatic logic [7:0] size_mask(input logic [3:0] sz);
    case (sz)
      SZ_B:    size_mask = MASK_B;
      SZ_H:    size_mask = MASK_H;
      SZ_W:    size_mask = MASK_W;
      SZ_D:    size_mask = MASK_D;
      default: size_mask = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_load_formatter.sv
// Extracts the addressed bytes from an aligned dcache word and sign/zero-extends them.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module load_formatter
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [2:0]        offset,
  input  logic [3:0]        size,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] load_data
);

  logic [DATA_W-1:0] sh;

  // Shift the addressed byte to lane 0, then extend according to size
  always_comb begin
    sh = rdata >> {offset, 3'b000};
    load_data = sh;
    case (size)
      SZ_B: load_data = is_unsigned ? {{(DATA_W-8){1'b0}}, sh[7:0]}
                                    : {{(DATA_W-8){sh[7]}}, sh[7:0]};
      SZ_H: load_data = is_unsigned ? {{(DATA_W-16){1'b0}}, sh[15:0]}
                                    : {{(DATA_W-16){sh[15]}}, sh[15:0]};
      SZ_W: load_data = is_unsigned ? {{(DATA_W-32){1'b0}}, sh[31:0]}
                                    : {{(DATA_W-32){sh[31]}}, sh[31:0]};
      default: load_data = sh;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues one dcache request per load/store and formats the returned load data.
// Latency: detect, request handshake, response -- 3 cycles minimum; stall drops on the response cycle.
// Backpressure: request fields held until req_ready; mem_stall freezes the pipe while an access is open.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              valid,
  input  logic              is_load,
  input  logic              is_store,
  input  logic              is_unsigned,
  input  logic [3:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_address,
  input  logic [DATA_W-1:0] store_data,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  output logic              req_wen,
  output logic [DATA_W-1:0] req_wdata,
  output logic [7:0]        req_wmask,
  input  logic              resp_valid,
  input  logic [DATA_W-1:0] resp_rdata,
  output logic              mem_stall,
  output logic [DATA_W-1:0] load_data,
  output logic              misalign
);

  state_t            state, state_nxt;
  logic              mem_op, illegal, off_bad, latch_en;
  logic [2:0]        offset;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wen, r_uns;
  logic [DATA_W-1:0] r_wdata;
  logic [7:0]        r_wmask;
  logic [3:0]        r_size;
  logic [2:0]        r_off;
  logic [DATA_W-1:0] fmt_data;

  assign offset = ls_address[2:0];
  assign mem_op = valid & (is_load | is_store);

  // Alignment and legality check; an illegal encoding is reported the same way as misalignment
  always_comb begin
    illegal = is_load & is_store;
    off_bad = 1'b0;
    case (ls_size)
      SZ_B:    off_bad = 1'b0;
      SZ_H:    off_bad = offset[0];
      SZ_W:    off_bad = |offset[1:0];
      SZ_D:    off_bad = |offset;
      default: illegal = 1'b1;
    endcase
    misalign = mem_op & (illegal | off_bad);
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // FSM next state, request valid and stall
  always_comb begin
    state_nxt = state;
    latch_en  = 1'b0;
    req_valid = 1'b0;
    mem_stall = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_op && !misalign) begin
          latch_en  = 1'b1;
          mem_stall = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        req_valid = 1'b1;
        mem_stall = 1'b1;
        if (req_ready) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (resp_valid) state_nxt = ST_IDLE;
        else            mem_stall = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Capture the access on detect; fields stay frozen until the next access is accepted
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_size  <= '0;
      r_uns   <= 1'b0;
      r_off   <= '0;
    end else if (latch_en) begin
      r_addr  <= {ls_address[ADDR_W-1:3], 3'b000};
      r_wen   <= is_store;
      r_wdata <= store_data << {offset, 3'b000};
      r_wmask <= size_mask(ls_size) << offset;
      r_size  <= ls_size;
      r_uns   <= is_unsigned;
      r_off   <= offset;
    end
  end

  assign req_addr  = r_addr;
  assign req_wen   = r_wen;
  assign req_wdata = r_wdata;
  assign req_wmask = r_wmask;

  load_formatter #(.DATA_W(DATA_W)) u_fmt (
    .rdata       (resp_rdata),
    .offset      (r_off),
    .size        (r_size),
    .is_unsigned (r_uns),
    .load_data   (fmt_data)
  );

  // Load result is presented only on the response cycle of a load
  assign load_data = (state == ST_WAIT && resp_valid && !r_wen) ? fmt_data : '0;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clock, reset_n, valid, is_load, is_store, is_unsigned;
  logic [3:0]  ls_size;
  logic [63:0] ls_address, store_data;
  logic        req_valid, req_ready, req_wen;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        mem_stall, misalign;
  logic [63:0] load_data;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  mem_stage #(.ADDR_W(64), .DATA_W(64)) dut (
    .clock(clock), .reset_n(reset_n), .valid(valid), .is_load(is_load),
    .is_store(is_store), .is_unsigned(is_unsigned), .ls_size(ls_size),
    .ls_address(ls_address), .store_data(store_data), .req_valid(req_valid),
    .req_ready(req_ready), .req_addr(req_addr), .req_wen(req_wen),
    .req_wdata(req_wdata), .req_wmask(req_wmask), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .mem_stall(mem_stall), .load_data(load_data),
    .misalign(misalign)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference: access is legal only for one of load/store, a power-of-two size, natural alignment
  function automatic logic ref_mis(input logic ld, input logic st, input logic [3:0] sz,
                                   input logic [63:0] addr);
    int nbytes;
    if (ld && st) return 1'b1;
    if ($countones(sz) != 1) return 1'b1;
    nbytes = int'(sz);
    return (addr % nbytes) != 0;
  endfunction

  // Reference: pick nbytes starting at byte (addr mod 8), extend to 64 bits
  function automatic logic [63:0] ref_load(input logic [63:0] rd, input logic [63:0] addr,
                                           input logic [3:0] sz, input logic uns);
    logic [127:0] v, m;
    int nbytes, off;
    nbytes = int'(sz);
    off    = int'(addr % 8);
    m = (128'd1 << (8 * nbytes)) - 128'd1;
    v = ({64'd0, rd} >> (8 * off)) & m;
    if (!uns && v[8*nbytes-1]) v = v | ~m;
    return v[63:0];
  endfunction

  // Drive one MEM-stage instruction and play the dcache with the given delays
  task automatic access(input logic ld, input logic st, input logic uns, input logic [3:0] sz,
                        input logic [63:0] addr, input logic [63:0] sd, input logic [63:0] rd,
                        input int rdly, input int pdly);
    int stalls;
    logic [7:0]  wmask_exp;
    logic [63:0] wdata_exp;
    logic        mis_exp;
    stalls = 0;
    valid = 1'b1; is_load = ld; is_store = st; is_unsigned = uns;
    ls_size = sz; ls_address = addr; store_data = sd;
    req_ready = 1'b0; resp_valid = 1'b0;
    #1;
    mis_exp = ref_mis(ld, st, sz, addr);
    chk("misalign", misalign, mis_exp);
    if (mis_exp) begin
      chk("mis_stall", mem_stall, 0);
      chk("mis_req_valid", req_valid, 0);
      step();
      chk("mis_req_valid_next", req_valid, 0);
      valid = 1'b0;
      return;
    end
    wmask_exp = 8'(((1 << int'(sz)) - 1) << (addr % 8));
    wdata_exp = sd << (8 * (addr % 8));
    chk("detect_req_valid", req_valid, 0);
    if (mem_stall) stalls++;
    step();
    for (int i = 0; i <= rdly; i++) begin
      chk("req_valid", req_valid, 1);
      chk("req_addr", req_addr, addr & ~64'h7);
      chk("req_wen", req_wen, st);
      chk("req_wdata", req_wdata, wdata_exp);
      chk("req_wmask", req_wmask, wmask_exp);
      if (mem_stall) stalls++;
      req_ready = (i == rdly);
      step();
    end
    req_ready = 1'b0;
    for (int j = 0; j <= pdly; j++) begin
      chk("wait_req_valid", req_valid, 0);
      resp_valid = (j == pdly);
      resp_rdata = rd;
      #1;
      if (mem_stall) stalls++;
      chk("wait_stall", mem_stall, !resp_valid);
      chk("load_data", load_data, (resp_valid && ld) ? ref_load(rd, addr, sz, uns) : 64'd0);
      step();
    end
    resp_valid = 1'b0; valid = 1'b0;
    #1;
    chk("idle_stall", mem_stall, 0);
    chk("idle_req_valid", req_valid, 0);
    chk("stall_cycles", 64'(stalls), 64'(rdly + pdly + 2));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; valid = 1'b0; is_load = 1'b0; is_store = 1'b0; is_unsigned = 1'b0;
    ls_size = SZ_D; ls_address = '0; store_data = '0; req_ready = 1'b0;
    resp_valid = 1'b0; resp_rdata = '0;
    step(); step();
    chk("rst_req_valid", req_valid, 0);
    chk("rst_req_addr", req_addr, 0);
    chk("rst_req_wen", req_wen, 0);
    chk("rst_req_wdata", req_wdata, 0);
    chk("rst_req_wmask", req_wmask, 0);
    chk("rst_stall", mem_stall, 0);
    chk("rst_load_data", load_data, 0);
    reset_n = 1'b1;
    step();

    // Directed cases
    access(1, 0, 0, SZ_D, 64'h1000, 64'h0, 64'h1122334455667788, 0, 0);
    access(1, 0, 0, SZ_B, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 0, 0);
    access(1, 0, 1, SZ_B, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 0, 0);
    access(0, 1, 0, SZ_H, 64'h2002, 64'hBEEF, 64'h0, 0, 1);
    chk("sh_wdata_hi", {48'd0, req_wdata[31:16]}, 64'hBEEF);
    access(1, 0, 0, SZ_W, 64'h3002, 64'h0, 64'h0, 0, 0);
    access(0, 1, 0, SZ_W, 64'h3004, 64'hCAFEF00D, 64'h0, 4, 2);
    access(1, 0, 0, SZ_H, 64'h5006, 64'h0, 64'h9ABC_0000_0000_0000, 1, 0);
    access(1, 1, 0, SZ_W, 64'h6000, 64'h0, 64'h0, 0, 0);
    access(1, 0, 0, 4'b0011, 64'h6000, 64'h0, 64'h0, 0, 0);

    // Reset asserted while waiting for the response
    valid = 1'b1; is_load = 1'b1; is_store = 1'b0; is_unsigned = 1'b0;
    ls_size = SZ_D; ls_address = 64'h4000;
    #1;
    step();
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    chk("wait_before_rst_stall", mem_stall, 1);
    #1;
    reset_n = 1'b0; valid = 1'b0;
    #1;
    chk("rst_mid_req_valid", req_valid, 0);
    chk("rst_mid_stall", mem_stall, 0);
    chk("rst_mid_req_addr", req_addr, 0);
    resp_valid = 1'b1; resp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    #1;
    chk("rst_mid_load_data", load_data, 0);
    step();
    reset_n = 1'b1;
    step();
    chk("stray_resp_load_data", load_data, 0);
    chk("stray_resp_stall", mem_stall, 0);
    resp_valid = 1'b0;
    step();
    chk("post_rst_req_valid", req_valid, 0);
    access(1, 0, 0, SZ_D, 64'h4008, 64'h0, 64'h0123456789ABCDEF, 0, 0);

    // Randomized accesses against the reference model
    for (int k = 0; k < 40; k++) begin
      logic ld, st, uns;
      logic [3:0] sz;
      logic [63:0] addr, sd, rd;
      ld  = 1'($urandom_range(0, 1));
      st  = !ld;
      if ($urandom_range(0, 15) == 0) st = 1'b1;
      uns = 1'($urandom_range(0, 1));
      sz  = 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) sz = 4'($urandom_range(0, 15));
      addr = {32'($urandom), 32'($urandom)};
      if ($urandom_range(0, 3) != 0 && $countones(sz) == 1)
        addr = addr & ~(64'(sz) - 64'd1);
      sd = {32'($urandom), 32'($urandom)};
      rd = {32'($urandom), 32'($urandom)};
      access(ld, st, uns, sz, addr, sd, rd, $urandom_range(0, 3), $urandom_range(0, 3));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
